div3_seq_ctrl: RTL and testbench

DIV3_SEQ_CTRL -- requirements
Module: div3_seq_ctrl

---
 rtl/div3_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_div3_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div3_seq_ctrl.sv
// div3_seq_ctrl: sequential radix-4 unsigned divide-by-3 with valid/ready handshakes.
// Ports: clk, rst (sync, active-high), flush (abort to IDLE),
//   in_valid/in_ready/in_data (dividend), out_valid/out_ready/out_quot (quotient),
//   out_rem (remainder, only when DIV3_SEQ_REM_OUT_EN is defined), busy (RUN state).
// Build option: define DIV3_SEQ_REM_OUT_EN to add the registered out_rem port.
module div3_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
`ifdef DIV3_SEQ_REM_OUT_EN
  output logic [1:0]       out_rem,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH/2 + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [1:0]       r_q;
  logic [1:0]       dig;
  logic [3:0]       t;
  logic [1:0]       qd;
  logic [1:0]       rn;
  logic             accept;
  logic             step;
  logic             fin;

`ifdef DIV3_SEQ_REM_OUT_EN
  logic [1:0] rem_q;
  assign out_rem = rem_q;
`endif

  assign dig    = a_q[WIDTH-1:WIDTH-2];
  assign t      = {r_q, dig};
  assign accept = (state_q == IDLE) && in_valid && !flush;
  assign step   = (state_q == RUN) && !flush && (cnt_q != '0);
  assign fin    = (state_q == RUN) && !flush && (cnt_q == '0);

  // t = 4*r + d is at most 11 since r <= 2; small lookup
  // yields {t div 3, t mod 3}.
  always_comb begin
    qd = 2'd0;
    rn = 2'd0;
    case (t)
      4'd0:  begin qd = 2'd0; rn = 2'd0; end
      4'd1:  begin qd = 2'd0; rn = 2'd1; end
      4'd2:  begin qd = 2'd0; rn = 2'd2; end
      4'd3:  begin qd = 2'd1; rn = 2'd0; end
      4'd4:  begin qd = 2'd1; rn = 2'd1; end
      4'd5:  begin qd = 2'd1; rn = 2'd2; end
      4'd6:  begin qd = 2'd2; rn = 2'd0; end
      4'd7:  begin qd = 2'd2; rn = 2'd1; end
      4'd8:  begin qd = 2'd2; rn = 2'd2; end
      4'd9:  begin qd = 2'd3; rn = 2'd0; end
      4'd10: begin qd = 2'd3; rn = 2'd1; end
      4'd11: begin qd = 2'd3; rn = 2'd2; end
      default: begin qd = 2'd0; rn = 2'd0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) state_d = RUN;
        RUN:  if (cnt_q == '0) state_d = DONE;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Digits are consumed while cnt is non-zero; the cnt==0 RUN
  // cycle moves the finished quotient into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      q_q      <= '0;
      r_q      <= 2'd0;
      out_quot <= '0;
`ifdef DIV3_SEQ_REM_OUT_EN
      rem_q    <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= in_data;
        q_q   <= '0;
        r_q   <= 2'd0;
        cnt_q <= CW'(WIDTH/2);
      end
      if (step) begin
        a_q   <= {a_q[WIDTH-3:0], 2'b00};
        q_q   <= {q_q[WIDTH-3:0], qd};
        r_q   <= rn;
        cnt_q <= cnt_q - CW'(1);
      end
      if (fin) begin
        out_quot <= q_q;
`ifdef DIV3_SEQ_REM_OUT_EN
        rem_q    <= r_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_div3_seq_ctrl.sv
// tb_div3_seq_ctrl: vector table, scoreboard and corner sequences
// for div3_seq_ctrl at WIDTH=16.
module tb_div3_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quot;
  logic         busy;
`ifdef DIV3_SEQ_REM_OUT_EN
  logic [1:0]   out_rem;
`endif

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] q;
    logic [1:0]   r;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [1:0]   r;
  } exp_t;

  vec_t tbl[7];
  exp_t sb[$];

  div3_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
`ifdef DIV3_SEQ_REM_OUT_EN
    .out_rem   (out_rem),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_out_quot"}, 32'(out_quot), 0);
`ifdef DIV3_SEQ_REM_OUT_EN
    chk({tag, "_out_rem"}, 32'(out_rem), 0);
`endif
  endtask

  // Waits for out_valid; lat counts edges after the accepting edge.
  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_data = W'($urandom);
      tick();
      lat++;
    end
    ok = out_valid;
    if (!ok) chk("timeout_out_valid", 0, 1);
  endtask

  task automatic accept(input logic [W-1:0] d, input bit push);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    if (push) begin
      e.q = W'(d / 3);
      e.r = 2'(d % 3);
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] d, input bit chk_lat,
                        input int hold, input string tag);
    int   lat;
    bit   ok;
    exp_t e;
    logic [W-1:0] q0;
    accept(d, 1'b1);
    wait_valid(lat, ok);
    e = sb.pop_front();
    if (ok) begin
      if (chk_lat) chk({tag, "_latency"}, lat, 9);
      chk({tag, "_quot"}, 32'(out_quot), 32'(e.q));
`ifdef DIV3_SEQ_REM_OUT_EN
      chk({tag, "_rem"}, 32'(out_rem), 32'(e.r));
`endif
      q0 = out_quot;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        tick();
        chk({tag, "_bp_hold"},
            {15'd0, out_valid, in_ready, out_quot},
            {15'd0, 1'b1, 1'b0, q0});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (hold > 0 || chk_lat)
        chk({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    end
  endtask

  initial begin
    int   lat;
    bit   ok;
    bit   seen;
    logic [W-1:0] v;

    tbl[0] = '{16'd0,     16'd0,     2'd0};
    tbl[1] = '{16'hFFFF,  16'd21845, 2'd0};
    tbl[2] = '{16'hFFFE,  16'd21844, 2'd2};
    tbl[3] = '{16'd100,   16'd33,    2'd1};
    tbl[4] = '{16'd7,     16'd2,     2'd1};
    tbl[5] = '{16'd11,    16'd3,     2'd2};
    tbl[6] = '{16'h8000,  16'd10922, 2'd2};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    // table vectors: constants checked directly against DUT
    for (int i = 0; i < 7; i++) begin
      accept(tbl[i].din, 1'b0);
      wait_valid(lat, ok);
      if (ok) begin
        chk("tbl_latency", lat, 9);
        chk("tbl_quot", 32'(out_quot), 32'(tbl[i].q));
`ifdef DIV3_SEQ_REM_OUT_EN
        chk("tbl_rem", 32'(out_rem), 32'(tbl[i].r));
`endif
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("tbl_idle", 32'(in_ready), 1);
    end

    // backpressure for 20 cycles
    run_op(16'd100, 1'b1, 20, "bp");

    // flush in IDLE with in_valid: no accept
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd55;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle", {30'd0, busy, in_ready}, 32'b01);

    // flush on 4th RUN cycle together with in_valid
    accept(16'd100, 1'b0);
    tick(); tick(); tick();
    chk("pre_flush_busy", 32'(busy), 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_run_idle", {30'd0, in_ready, busy}, 32'b10);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 0);
    run_op(16'd7, 1'b1, 0, "after_flush");

    // reset mid-RUN
    accept(16'hFFFF, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_run");

    // reset in DONE
    accept(16'hFFFF, 1'b0);
    wait_valid(lat, ok);
    chk("done_quot", 32'(out_quot), 21845);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_done");

    // random sweep through the scoreboard
    for (int i = 0; i < 1500; i++) begin
      v = W'($urandom);
      run_op(v, 1'b0, (i % 50 == 0) ? 3 : 0, "sweep");
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
